sram_wb_responder: RTL and testbench
====================================

Name: sram_wb_responder

Overview:
- Wishbone classic responder (slave) that serves the data-memory master's bus cycles from an external asynchronous 32-bit SRAM (BaseRAM/ExtRAM class).
- Translates each Wishbone cycle into a fixed-timing SRAM read or write.
- Returns a single-cycle registered ack.
- Sits between the Wishbone interconnect/arbiter and the top-level SRAM pads; tri-state buffering of the data pins is done at top level.

Parameters:
- DATA_WIDTH, 32, Wishbone data width.
- ADDR_WIDTH, 32, Wishbone address width.
- SRAM_ADDR_WIDTH, 20, SRAM word-address width.
- SRAM_DATA_WIDTH, 32, SRAM data width; must equal DATA_WIDTH.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  transfer acknowledge, one-cycle pulse.
- wb_adr_i  in  ADDR_WIDTH  byte address.
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_dat_o  out  DATA_WIDTH  read data.
- wb_sel_i  in  DATA_WIDTH/8  byte lane enables.
- wb_we_i  in  1  1 = write, 0 = read.
- sram_addr  out  SRAM_ADDR_WIDTH  word address.
- sram_data_i  in  SRAM_DATA_WIDTH  data from SRAM pins.
- sram_data_o  out  SRAM_DATA_WIDTH  data to SRAM pins.
- sram_data_oe  out  1  1 = drive pins with sram_data_o.
- sram_ce_n  out  1  chip enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable, active low.
- sram_be_n  out  SRAM_DATA_WIDTH/8  byte enables, active low.

Behaviour:
- Reset (rst_i is asynchronous, active-high; clock is clk_i). On reset every output takes its reset value immediately, including when a transaction is in flight:
  - wb_ack_o=0, wb_dat_o=0, sram_addr=0, sram_data_o=0, sram_data_oe=0
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=all 1
  - state=IDLE
- All outputs are registered; there are no combinational paths from Wishbone inputs to outputs.
- Address mapping: sram_addr = wb_adr_i[SRAM_ADDR_WIDTH+1:2]. wb_adr_i[1:0] is ignored, and byte selection is carried only by wb_sel_i. Upper address bits are ignored (aliasing is the interconnect's problem).
- Byte enables: sram_be_n = ~wb_sel_i, latched at request accept and held until the transaction ends. Reads return the full word; the master extracts the lanes it needs.
- States: IDLE, RD1, RD2, WR1, WR2, WR3, DONE.
- IDLE:
  - If wb_cyc_i & wb_stb_i & ~wb_ack_o, latch address, sel and data.
  - Assert sram_ce_n=0.
  - If ~we: set sram_oe_n=0 and go to RD1.
  - If we: set sram_data_o=wb_dat_i, sram_data_oe=1 and go to WR1.
- RD1: hold the strobes; go to RD2.
- RD2: wb_dat_o <= sram_data_i; deassert ce_n/oe_n, set be_n to all 1; go to DONE.
- WR1: sram_we_n=0; go to WR2.
- WR2: hold sram_we_n=0; go to WR3.
- WR3: sram_we_n=1 while data and ce are still held (hold time); go to DONE.
- DONE:
  - Release ce_n, set be_n to all 1, sram_data_oe=0.
  - wb_ack_o=1 for exactly one cycle, only if wb_cyc_i & wb_stb_i are still high. If the master abandoned the cycle, no ack is issued.
  - Go to IDLE.
- Latency, counted from the request-accept edge to the edge that registers ack:
  - Read: 3 cycles.
  - Write: 4 cycles.
- Back-to-back requests: IDLE never accepts in the cycle where wb_ack_o=1, which guards against a stale stb. The next request is accepted one cycle after the ack.
- wb_sel_i=0 on a write: the full write sequence runs with be_n all 1 (no bytes change), and ack is still issued.
- wb_dat_o holds the last read data until the next read completes; writes do not modify it.
- Protocol rules:
  - Inputs that change mid-transaction are ignored, because values are latched at accept.
  - sram_we_n and sram_oe_n are never low in the same cycle.
  - sram_data_oe is never 1 while sram_oe_n=0.

Optional Feature:
- Macro: SRAM_WB_RESPONDER_WAIT_EN.
- Defined: adds one extra wait state after RD1 (RDW) and one after WR2 (WRW) with strobes held, for slow SRAM parts. Read latency becomes 4 cycles and write latency 5 cycles.
- Undefined: timing exactly as in Behaviour.

Test Plan:
- Word write then read:
  - Stimulus: write adr=0x0000_0010, sel=4'hF, dat=0xDEAD_BEEF; then read adr=0x10.
  - Required: sram_addr=0x00004, we_n low for 2 cycles, ack 4 cycles after accept; read returns wb_dat_o=0xDEAD_BEEF with ack 3 cycles after accept.
- Byte write:
  - Stimulus: write adr=0x13, sel=4'b1000, dat=0xAB00_0000 over a preloaded word 0x1122_3344.
  - Required: sram_be_n=4'b0111; the following read returns 0xAB22_3344.
- Back-to-back:
  - Stimulus: master holds cyc/stb through ack, then issues a new read next cycle.
  - Required: exactly one ack per transfer, no duplicate SRAM cycle, second read acked 3 cycles after its accept.
- Abandoned cycle:
  - Stimulus: stb dropped during RD1.
  - Required: SRAM read completes, no ack, returns to IDLE; a new request is served normally.
- Reset mid-write:
  - Stimulus: rst_i asserted in WR2.
  - Required: same cycle sram_we_n=1, sram_ce_n=1, sram_data_oe=0, wb_ack_o=0; state=IDLE after release.
- SRAM_WB_RESPONDER_WAIT_EN:
  - Stimulus: repeat the first scenario with the macro defined.
  - Required: read ack at 4 cycles, write ack at 5 cycles, we_n low for 3 cycles.

Source files
------------

// File: rtl/sram_wb_responder.sv
// Wishbone classic responder driving an async 32-bit SRAM with fixed-timing read/write cycles.
// Optional macro SRAM_WB_RESPONDER_WAIT_EN inserts one wait state per read (RDW) and write (WRW).
module sram_wb_responder #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 20,
  parameter int SRAM_DATA_WIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  output logic                         wb_ack_o,
  input  logic [ADDR_WIDTH-1:0]        wb_adr_i,
  input  logic [DATA_WIDTH-1:0]        wb_dat_i,
  output logic [DATA_WIDTH-1:0]        wb_dat_o,
  input  logic [DATA_WIDTH/8-1:0]      wb_sel_i,
  input  logic                         wb_we_i,
  output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr,
  input  logic [SRAM_DATA_WIDTH-1:0]   sram_data_i,
  output logic [SRAM_DATA_WIDTH-1:0]   sram_data_o,
  output logic                         sram_data_oe,
  output logic                         sram_ce_n,
  output logic                         sram_oe_n,
  output logic                         sram_we_n,
  output logic [SRAM_DATA_WIDTH/8-1:0] sram_be_n
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD1, S_RDW, S_RD2, S_WR1, S_WR2, S_WRW, S_WR3, S_DONE
  } state_t;

  localparam int BE_W = SRAM_DATA_WIDTH / 8;

  state_t                       r_state, w_state_nxt;
  logic                         r_ack, w_ack_nxt;
  logic [DATA_WIDTH-1:0]        r_dat_o, w_dat_o_nxt;
  logic [SRAM_ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
  logic [SRAM_DATA_WIDTH-1:0]   r_data_o, w_data_o_nxt;
  logic                         r_data_oe, w_data_oe_nxt;
  logic                         r_ce_n, w_ce_n_nxt;
  logic                         r_oe_n, w_oe_n_nxt;
  logic                         r_we_n, w_we_n_nxt;
  logic [BE_W-1:0]              r_be_n, w_be_n_nxt;

  // Byte offset and alias bits above the SRAM window are deliberately dropped.
  logic w_unused_adr;
  assign w_unused_adr = ^{wb_adr_i[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2], wb_adr_i[1:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_ack     <= 1'b0;
      r_dat_o   <= '0;
      r_addr    <= '0;
      r_data_o  <= '0;
      r_data_oe <= 1'b0;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_be_n    <= '1;
    end else begin
      r_state   <= w_state_nxt;
      r_ack     <= w_ack_nxt;
      r_dat_o   <= w_dat_o_nxt;
      r_addr    <= w_addr_nxt;
      r_data_o  <= w_data_o_nxt;
      r_data_oe <= w_data_oe_nxt;
      r_ce_n    <= w_ce_n_nxt;
      r_oe_n    <= w_oe_n_nxt;
      r_we_n    <= w_we_n_nxt;
      r_be_n    <= w_be_n_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ack_nxt     = 1'b0;
    w_dat_o_nxt   = r_dat_o;
    w_addr_nxt    = r_addr;
    w_data_o_nxt  = r_data_o;
    w_data_oe_nxt = r_data_oe;
    w_ce_n_nxt    = r_ce_n;
    w_oe_n_nxt    = r_oe_n;
    w_we_n_nxt    = r_we_n;
    w_be_n_nxt    = r_be_n;
    unique case (r_state)
      S_IDLE: begin
        // Refusing while ack is high keeps a stale strobe from starting a second cycle.
        if (wb_cyc_i && wb_stb_i && !r_ack) begin
          w_addr_nxt = wb_adr_i[SRAM_ADDR_WIDTH+1:2];
          w_be_n_nxt = ~wb_sel_i;
          w_ce_n_nxt = 1'b0;
          if (wb_we_i) begin
            w_data_o_nxt  = wb_dat_i;
            w_data_oe_nxt = 1'b1;
            w_state_nxt   = S_WR1;
          end else begin
            w_oe_n_nxt  = 1'b0;
            w_state_nxt = S_RD1;
          end
        end
      end
`ifdef SRAM_WB_RESPONDER_WAIT_EN
      S_RD1: w_state_nxt = S_RDW;
`else
      S_RD1: w_state_nxt = S_RD2;
`endif
      S_RDW: w_state_nxt = S_RD2;
      S_RD2: begin
        w_dat_o_nxt = sram_data_i;
        w_ce_n_nxt  = 1'b1;
        w_oe_n_nxt  = 1'b1;
        w_be_n_nxt  = '1;
        w_state_nxt = S_DONE;
      end
      S_WR1: begin
        w_we_n_nxt  = 1'b0;
        w_state_nxt = S_WR2;
      end
`ifdef SRAM_WB_RESPONDER_WAIT_EN
      S_WR2: w_state_nxt = S_WRW;
`else
      S_WR2: w_state_nxt = S_WR3;
`endif
      S_WRW: w_state_nxt = S_WR3;
      S_WR3: begin
        w_we_n_nxt  = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_ce_n_nxt    = 1'b1;
        w_be_n_nxt    = '1;
        w_data_oe_nxt = 1'b0;
        w_ack_nxt     = wb_cyc_i && wb_stb_i;
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign wb_ack_o     = r_ack;
  assign wb_dat_o     = r_dat_o;
  assign sram_addr    = r_addr;
  assign sram_data_o  = r_data_o;
  assign sram_data_oe = r_data_oe;
  assign sram_ce_n    = r_ce_n;
  assign sram_oe_n    = r_oe_n;
  assign sram_we_n    = r_we_n;
  assign sram_be_n    = r_be_n;

endmodule

// File: tb/tb_sram_wb_responder.sv
// Bench for sram_wb_responder: random Wishbone traffic against a word-array memory model,
// with a scoreboard that checks every ack for latency, data and the SRAM strobe pattern.
module tb_sram_wb_responder;

`ifdef SRAM_WB_RESPONDER_WAIT_EN
  localparam int WAIT = 1;
`else
  localparam int WAIT = 0;
`endif
  localparam int RD_LAT = 3 + WAIT;
  localparam int WR_LAT = 4 + WAIT;

  logic        clk_i, rst_i;
  logic        wb_cyc_i, wb_stb_i, wb_ack_o, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic [19:0] sram_addr;
  logic [31:0] sram_data_i, sram_data_o;
  logic        sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;

  sram_wb_responder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .sram_addr(sram_addr), .sram_data_i(sram_data_i), .sram_data_o(sram_data_o),
    .sram_data_oe(sram_data_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pre(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  // Asynchronous SRAM part: 256 words, byte-masked writes while we_n and ce_n are low.
  logic [31:0] sram_mem [256];
  assign sram_data_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[7:0]] : 32'hBAD0_F00D;
  initial begin
    for (int i = 0; i < 256; i++) sram_mem[i] = pre(i);
    forever begin
      @(negedge clk_i);
      if (!sram_ce_n && !sram_we_n && sram_data_oe)
        for (int b = 0; b < 4; b++)
          if (!sram_be_n[b]) sram_mem[sram_addr[7:0]][8*b +: 8] = sram_data_o[8*b +: 8];
    end
  end

  typedef struct {
    bit          wr;
    int          ack_edge;
    logic [31:0] dat;
    logic [19:0] addr;
    logic [3:0]  be_n;
  } exp_t;
  exp_t sb[$];

  logic [31:0] ref_mem [256];
  logic [31:0] last_rd;
  int          ready_edge;
  int          ack_cnt = 0;

  int          we_lo, oe_lo, ce_falls;
  logic [19:0] seen_addr;
  logic [3:0]  seen_be;
  logic        prev_ce_n = 1'b1;

  // Monitor: SRAM bus statistics, protocol rules and the ack scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (!rst_i) begin
        chk("we_oe_overlap", {31'd0, !sram_we_n && !sram_oe_n}, 32'd0);
        chk("oe_drive_clash", {31'd0, sram_data_oe && !sram_oe_n}, 32'd0);
      end
      if (!sram_we_n) we_lo++;
      if (!sram_oe_n) oe_lo++;
      if (!sram_ce_n && prev_ce_n) ce_falls++;
      if (!sram_ce_n) begin
        seen_addr = sram_addr;
        seen_be   = sram_be_n;
      end
      prev_ce_n = sram_ce_n;
      if (wb_ack_o) begin
        ack_cnt++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ack: got ack=1 required ack=0 (edge %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("ack_edge", 32'(cyc), 32'(e.ack_edge));
          chk("wb_dat_o", wb_dat_o, e.dat);
          chk("sram_addr", {12'd0, seen_addr}, {12'd0, e.addr});
          chk("sram_be_n", {28'd0, seen_be}, {28'd0, e.be_n});
          chk("we_n_low_cycles", 32'(we_lo), e.wr ? 32'(2 + WAIT) : 32'd0);
          chk("oe_n_low_cycles", 32'(oe_lo), e.wr ? 32'd0 : 32'(2 + WAIT));
          chk("ce_n_cycles", 32'(ce_falls), 32'd1);
        end
      end else if (sb.size() > 0 && cyc > sb[0].ack_edge) begin
        e = sb.pop_front();
        n_cmp++;
        n_err++;
        $display("FAIL missing_ack: got no ack by edge %0d required ack at edge %0d", cyc, e.ack_edge);
      end
    end
  end

  // Issues one request at a negedge; returns at the negedge after the ack (or abandoned end).
  task automatic txn(input bit wr, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input bit abandon, input bit hold);
    int   lat, acc, idx, ack0;
    exp_t e;
    lat = wr ? WR_LAT : RD_LAT;
    acc = (cyc + 1 > ready_edge) ? cyc + 1 : ready_edge;
    idx = int'(adr[9:2]);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = wr;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
    end else begin
      last_rd = ref_mem[idx];
    end
    e.wr = wr; e.ack_edge = acc + lat; e.dat = last_rd;
    e.addr = adr[21:2]; e.be_n = ~sel;
    we_lo = 0; oe_lo = 0; ce_falls = 0; seen_addr = 'x; seen_be = 'x;
    if (!abandon) sb.push_back(e);
    ack0 = ack_cnt;
    while (cyc < acc) @(negedge clk_i);
    if (abandon) begin
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
    end
    wb_we_i  = 1'($urandom_range(1));
    wb_adr_i = $urandom;
    wb_dat_i = $urandom;
    wb_sel_i = 4'($urandom_range(15));
    while (cyc < acc + lat) @(negedge clk_i);
    if (abandon) begin
      ready_edge = acc + lat + 1;
      @(negedge clk_i);
      chk("abandon_no_ack", 32'(ack_cnt - ack0), 32'd0);
    end else begin
      ready_edge = acc + lat + 2;
      if (!hold) begin
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},   {31'd0, wb_ack_o}, 32'd0);
    chk({tag, "_dat_o"}, wb_dat_o, 32'd0);
    chk({tag, "_addr"},  {12'd0, sram_addr}, 32'd0);
    chk({tag, "_sdat"},  sram_data_o, 32'd0);
    chk({tag, "_oe"},    {31'd0, sram_data_oe}, 32'd0);
    chk({tag, "_ce_n"},  {31'd0, sram_ce_n}, 32'd1);
    chk({tag, "_oe_n"},  {31'd0, sram_oe_n}, 32'd1);
    chk({tag, "_we_n"},  {31'd0, sram_we_n}, 32'd1);
    chk({tag, "_be_n"},  {28'd0, sram_be_n}, 32'hF);
  endtask

  initial begin
    logic [31:0] r, adr;
    bit          wr, ab, hold;
    int          acc;
    for (int i = 0; i < 256; i++) ref_mem[i] = pre(i);
    last_rd = 32'd0;
    ready_edge = 0;
    rst_i = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0;   wb_dat_i = '0;   wb_sel_i = '0;
    #1;
    chk_reset_outputs("por");
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Word write then read, then a byte write over a freshly written word.
    txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
    txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b0);
    chk("word_rd_value", wb_dat_o, 32'hDEAD_BEEF);
    txn(1'b1, 32'h0000_0010, 32'h1122_3344, 4'hF, 1'b0, 1'b0);
    txn(1'b1, 32'h0000_0013, 32'hAB00_0000, 4'b1000, 1'b0, 1'b0);
    txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b0);
    chk("byte_wr_value", wb_dat_o, 32'hAB22_3344);

    // Back-to-back with strobe held through the ack, then an abandoned read.
    txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b1);
    txn(1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b0, 1'b0);
    txn(1'b0, 32'h0000_0024, 32'h0, 4'hF, 1'b1, 1'b0);
    txn(1'b0, 32'h0000_0024, 32'h0, 4'h3, 1'b0, 1'b0);
    txn(1'b1, 32'h0000_0028, 32'h0000_5A00, 4'h0, 1'b0, 1'b0);

    // Reset while we_n is low in WR2; the word written matches the model either way.
    acc = (cyc + 1 > ready_edge) ? cyc + 1 : ready_edge;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'h0000_0030; wb_dat_i = ref_mem[12]; wb_sel_i = 4'hF;
    while (cyc < acc + 2) @(negedge clk_i);
    chk("wr2_we_n_low", {31'd0, sram_we_n}, 32'd0);
    rst_i = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    last_rd = 32'd0;
    ready_edge = cyc + 1;
    txn(1'b0, 32'h0000_0030, 32'h0, 4'hF, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      r    = $urandom;
      adr  = r & 32'hFFC0_03FF;
      wr   = 1'($urandom_range(1));
      ab   = ($urandom_range(9) == 0);
      hold = ($urandom_range(2) == 0);
      txn(wr, adr, $urandom, 4'($urandom_range(15)), ab, hold);
      if (!hold || ab) repeat ($urandom_range(2)) @(negedge clk_i);
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    repeat (8) @(negedge clk_i);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
